// File: rtl/msx_config_loader.sv
// Parses the "MSXC" ioctl config stream into records and expands slot-bearing records into one slot-table write per 16 KB page.
// Record fields and first write appear the cycle after b7; ioctl_wait covers the expansion, and one late byte is absorbed by a holding register.
module msx_config_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        cfg_valid,
    output logic [4:0]  cfg_typ,
    output logic [3:0]  cfg_block_id,
    output logic [7:0]  cfg_block_count,
    output logic [1:0]  cfg_slot,
    output logic [1:0]  cfg_sub_slot,
    output logic [1:0]  cfg_start_block,
    output logic        cfg_internal_mapper,
    output logic [27:0] cfg_store_address,
    output logic        slot_wr,
    output logic [1:0]  slot_wr_slot,
    output logic [1:0]  slot_wr_sub,
    output logic [1:0]  slot_wr_page,
    output logic [1:0]  slot_wr_offset,
    output logic [3:0]  slot_wr_typ,
    output logic [3:0]  slot_wr_block_id,
    output logic [7:0]  record_count,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, HDR, REC, EXPAND, DONE, ERR} state_t;

    state_t      state_q;
    logic        dl_q, hold_vld_q, wait_q, cfg_valid_q, slot_wr_q, done_q, error_q, im_q;
    logic [2:0]  idx_q, k_q, i_q;
    logic [55:0] rec_q;
    logic [7:0]  hold_q, record_count_q, cnt_q;
    logic [4:0]  typ_q;
    logic [3:0]  id_q, styp_q;
    logic [1:0]  slot_q, sub_q, start_q, page_q, off_q;
    logic [27:0] addr_q;

    logic        dl_rise, dl_fall, byte_take, map_d;
    logic [7:0]  byte_dat, hdr_exp, b3_d;
    logic [4:0]  typ_d;
    logic [3:0]  styp_d;
    logic [2:0]  span_d, k_d;
    logic        unused_bits;

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    // A held byte is always older than the one on the bus, so it goes first.
    assign byte_take = hold_vld_q | ioctl_wr;
    assign byte_dat  = hold_vld_q ? hold_q : ioctl_dout;
    assign typ_d     = rec_q[4:0];
    assign b3_d      = rec_q[31:24];
    assign span_d    = 3'd4 - {1'b0, b3_d[6:5]};
    assign unused_bits = ^{rec_q[7:5], rec_q[15:12], rec_q[31]};

    always_comb begin
        case (idx_q[1:0])
            2'd1:    hdr_exp = 8'h53;
            2'd2:    hdr_exp = 8'h58;
            2'd3:    hdr_exp = 8'h43;
            default: hdr_exp = 8'h4D;
        endcase
    end

    always_comb begin
        styp_d = 4'd0;
        map_d  = 1'b1;
        k_d    = 3'd0;
        case (typ_d)
            5'd1:    styp_d = b3_d[4] ? 4'd5 : 4'd1;
            5'd2:    styp_d = 4'd2;
            5'd3:    styp_d = 4'd8;
            5'd4:    styp_d = 4'd6;
            5'd5:    styp_d = 4'd7;
            default: map_d  = 1'b0;
        endcase
        if (map_d) begin
            if (rec_q[23:16] < {5'd0, span_d}) k_d = rec_q[18:16];
            else                               k_d = span_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;  dl_q <= 1'b0;  hold_vld_q <= 1'b0;  hold_q <= 8'd0;
            wait_q <= 1'b0;  cfg_valid_q <= 1'b0;  slot_wr_q <= 1'b0;
            done_q <= 1'b0;  error_q <= 1'b0;  record_count_q <= 8'd0;
            idx_q <= 3'd0;  k_q <= 3'd0;  i_q <= 3'd0;  rec_q <= 56'd0;
            typ_q <= 5'd0;  id_q <= 4'd0;  cnt_q <= 8'd0;  styp_q <= 4'd0;
            slot_q <= 2'd0;  sub_q <= 2'd0;  start_q <= 2'd0;  im_q <= 1'b0;
            page_q <= 2'd0;  off_q <= 2'd0;  addr_q <= 28'd0;
        end else begin
            dl_q        <= ioctl_download;
            cfg_valid_q <= 1'b0;
            slot_wr_q   <= 1'b0;
            if (dl_rise) begin
                state_q <= HDR;  idx_q <= 3'd0;  hold_vld_q <= 1'b0;  wait_q <= 1'b0;
                done_q <= 1'b0;  error_q <= 1'b0;  record_count_q <= 8'd0;
            end else begin
                case (state_q)
                    HDR: begin
                        if (dl_fall) begin
                            state_q <= ERR;  error_q <= 1'b1;
                        end else if (ioctl_wr) begin
                            if (ioctl_dout != hdr_exp) begin
                                state_q <= ERR;  error_q <= 1'b1;
                            end else if (idx_q == 3'd3) begin
                                state_q <= REC;  idx_q <= 3'd0;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
                    REC: begin
                        if (dl_fall) begin
                            if (idx_q == 3'd0 && !hold_vld_q) begin
                                state_q <= DONE;  done_q <= 1'b1;
                            end else begin
                                state_q <= ERR;  error_q <= 1'b1;
                            end
                            hold_vld_q <= 1'b0;
                        end else if (byte_take) begin
                            hold_vld_q <= hold_vld_q & ioctl_wr;
                            hold_q     <= ioctl_dout;
                            if (idx_q != 3'd7) begin
                                rec_q <= {byte_dat, rec_q[55:8]};
                                idx_q <= idx_q + 3'd1;
                            end else begin
                                idx_q   <= 3'd0;
                                typ_q   <= typ_d;          id_q   <= rec_q[11:8];
                                cnt_q   <= rec_q[23:16];   slot_q <= b3_d[1:0];
                                sub_q   <= b3_d[3:2];      im_q   <= b3_d[4];
                                start_q <= b3_d[6:5];
                                addr_q  <= {byte_dat[3:0], rec_q[55:32]};
                                if (typ_d > 5'd9) begin
                                    state_q <= ERR;  error_q <= 1'b1;
                                end else begin
                                    state_q     <= EXPAND;
                                    cfg_valid_q <= 1'b1;
                                    wait_q      <= 1'b1;
                                    if (record_count_q != 8'hFF) record_count_q <= record_count_q + 8'd1;
                                    styp_q    <= styp_d;
                                    k_q       <= k_d;
                                    i_q       <= 3'd1;
                                    page_q    <= b3_d[6:5];
                                    off_q     <= 2'd0;
                                    slot_wr_q <= (k_d != 3'd0);
                                end
                            end
                        end
                    end
                    EXPAND: begin
                        if (dl_fall || (ioctl_wr && hold_vld_q)) begin
                            state_q <= ERR;  error_q <= 1'b1;  wait_q <= 1'b0;  hold_vld_q <= 1'b0;
                        end else begin
                            if (ioctl_wr) begin
                                hold_q <= ioctl_dout;  hold_vld_q <= 1'b1;
                            end
                            if (i_q < k_q) begin
                                slot_wr_q <= 1'b1;
                                page_q    <= start_q + i_q[1:0];
                                off_q     <= i_q[1:0];
                                i_q       <= i_q + 3'd1;
                            end else begin
                                wait_q  <= 1'b0;
                                state_q <= REC;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ioctl_wait          = wait_q;
    assign cfg_valid           = cfg_valid_q;
    assign cfg_typ             = typ_q;
    assign cfg_block_id        = id_q;
    assign cfg_block_count     = cnt_q;
    assign cfg_slot            = slot_q;
    assign cfg_sub_slot        = sub_q;
    assign cfg_start_block     = start_q;
    assign cfg_internal_mapper = im_q;
    assign cfg_store_address   = addr_q;
    assign slot_wr             = slot_wr_q;
    assign slot_wr_slot        = slot_q;
    assign slot_wr_sub         = sub_q;
    assign slot_wr_page        = page_q;
    assign slot_wr_offset      = off_q;
    assign slot_wr_typ         = styp_q;
    assign slot_wr_block_id    = id_q;
    assign record_count        = record_count_q;
    assign done                = done_q;
    assign error               = error_q;
endmodule

// File: tb/tb_msx_config_loader.sv
// Randomised stream bench for msx_config_loader, scored against a record-level model of the config format.
module tb_msx_config_loader;
    logic        clk = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait, cfg_valid, cfg_internal_mapper, slot_wr, done, error;
    logic [4:0]  cfg_typ;
    logic [3:0]  cfg_block_id, slot_wr_typ, slot_wr_block_id;
    logic [7:0]  cfg_block_count, record_count;
    logic [1:0]  cfg_slot, cfg_sub_slot, cfg_start_block;
    logic [1:0]  slot_wr_slot, slot_wr_sub, slot_wr_page, slot_wr_offset;
    logic [27:0] cfg_store_address;

    msx_config_loader dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .cfg_valid(cfg_valid),
        .cfg_typ(cfg_typ), .cfg_block_id(cfg_block_id), .cfg_block_count(cfg_block_count),
        .cfg_slot(cfg_slot), .cfg_sub_slot(cfg_sub_slot), .cfg_start_block(cfg_start_block),
        .cfg_internal_mapper(cfg_internal_mapper), .cfg_store_address(cfg_store_address),
        .slot_wr(slot_wr), .slot_wr_slot(slot_wr_slot), .slot_wr_sub(slot_wr_sub),
        .slot_wr_page(slot_wr_page), .slot_wr_offset(slot_wr_offset), .slot_wr_typ(slot_wr_typ),
        .slot_wr_block_id(slot_wr_block_id), .record_count(record_count), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  stim[$];
    logic [63:0] obs_cfg[$], exp_cfg[$];
    logic [15:0] obs_wr[$], exp_wr[$];
    logic        exp_done, exp_err;
    int          exp_cnt;
    logic        swr_prev = 1'b0, cv_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (cfg_valid) begin
                obs_cfg.push_back({11'd0, slot_wr, cfg_typ, cfg_block_id, cfg_block_count, cfg_slot,
                                   cfg_sub_slot, cfg_start_block, cfg_internal_mapper, cfg_store_address});
                check_eq("wait_with_vld", ioctl_wait, 1);
            end
            if (slot_wr) begin
                obs_wr.push_back({slot_wr_slot, slot_wr_sub, slot_wr_page, slot_wr_offset,
                                  slot_wr_typ, slot_wr_block_id});
                check_eq("wait_with_wr", ioctl_wait, 1);
            end
            if ((swr_prev && !slot_wr) || (cv_prev && !swr_prev))
                check_eq("wait_release", ioctl_wait, 0);
        end
        swr_prev = slot_wr;
        cv_prev  = cfg_valid;
    end

    task automatic add_hdr();
        stim.push_back(8'h4D); stim.push_back(8'h53); stim.push_back(8'h58); stim.push_back(8'h43);
    endtask

    task automatic add_rec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [31:0] addr);
        stim.push_back(b0); stim.push_back(b1); stim.push_back(b2); stim.push_back(b3);
        stim.push_back(addr[7:0]); stim.push_back(addr[15:8]);
        stim.push_back(addr[23:16]); stim.push_back(addr[31:24]);
    endtask

    // Expected outcome of sending the first n bytes of stim, record by record.
    task automatic model(input int n);
        logic [7:0] magic [4];
        int         styp_tab [10];
        magic    = '{8'h4D, 8'h53, 8'h58, 8'h43};
        styp_tab = '{0, 1, 2, 8, 6, 7, 0, 0, 0, 0};
        exp_cfg.delete(); exp_wr.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_cnt = 0;
        for (int i = 0; i < 4 && i < n; i++)
            if (stim[i] != magic[i]) begin exp_err = 1'b1; return; end
        if (n < 4) begin exp_err = 1'b1; return; end
        for (int r = 0; r < (n - 4) / 8; r++) begin
            int         base, styp, span, k;
            logic [7:0] c0, c1, c2, c3;
            logic [1:0] start;
            base = 4 + 8 * r;
            c0 = stim[base]; c1 = stim[base + 1]; c2 = stim[base + 2]; c3 = stim[base + 3];
            if (c0[4:0] > 9) begin exp_err = 1'b1; return; end
            exp_cnt++;
            styp  = styp_tab[c0[4:0]];
            if (c0[4:0] == 1 && c3[4]) styp = 5;
            start = c3[6:5];
            span  = 4 - start;
            k     = (styp == 0) ? 0 : ((c2 < span) ? c2 : span);
            exp_cfg.push_back({11'd0, (k > 0), c0[4:0], c1[3:0], c2, c3[1:0], c3[3:2], c3[6:5], c3[4],
                               stim[base + 7][3:0], stim[base + 6], stim[base + 5], stim[base + 4]});
            for (int i = 0; i < k; i++) begin
                logic [1:0] pg, off;
                logic [3:0] st;
                pg  = start + 2'(i);
                off = 2'(i);
                st  = 4'(styp);
                exp_wr.push_back({c3[1:0], c3[3:2], pg, off, st, c1[3:0]});
            end
        end
        if ((n - 4) % 8 != 0) exp_err = 1'b1;
        else                  exp_done = 1'b1;
    endtask

    task automatic start_dl();
        @(negedge clk);
        ioctl_download = 1'b1;
        @(negedge clk);
        obs_cfg.delete(); obs_wr.delete();
        @(negedge clk);
        check_eq("rise_clear", {done, error, record_count}, 0);
    endtask

    // HPS-like sender: reacts to ioctl_wait one cycle late; blind mode also pushes the one byte allowed as wait rises.
    task automatic send_stream(input int n, input bit blind);
        int   sent = 0, guard = 0;
        logic wprev = 1'b1;
        while (sent < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            ioctl_wr = 1'b0;
            if ((!ioctl_wait && !wprev && $urandom_range(0, 3) != 0) || (blind && ioctl_wait && !wprev)) begin
                ioctl_wr   = 1'b1;
                ioctl_dout = stim[sent];
                sent++;
            end
            wprev = ioctl_wait;
        end
        check_eq("send_done", sent, n);
    endtask

    task automatic finish_dl();
        int quiet = 0;
        for (int c = 0; c < 300 && quiet < 3; c++) begin
            @(negedge clk);
            ioctl_wr = 1'b0;
            quiet = ioctl_wait ? 0 : quiet + 1;
        end
        check_eq("wait_quiet", quiet >= 3, 1);
        ioctl_download = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("cfg_count", obs_cfg.size(), exp_cfg.size());
        for (int i = 0; i < exp_cfg.size() && i < obs_cfg.size(); i++) check_eq("cfg_rec", obs_cfg[i], exp_cfg[i]);
        check_eq("wr_count", obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) check_eq("wr_rec", obs_wr[i], exp_wr[i]);
        check_eq("done", done, exp_done);
        check_eq("error", error, exp_err);
        check_eq("record_count", record_count, exp_cnt);
    endtask

    task automatic run_download(input int n, input bit blind);
        start_dl();
        model(n);
        send_stream(n, blind);
        finish_dl();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_eq("reset_cfg", {ioctl_wait, cfg_valid, cfg_typ, cfg_block_id, cfg_block_count, cfg_slot,
                               cfg_sub_slot, cfg_start_block, cfg_internal_mapper, cfg_store_address}, 0);
        check_eq("reset_misc", {slot_wr, slot_wr_slot, slot_wr_sub, slot_wr_page, slot_wr_offset,
                                slot_wr_typ, slot_wr_block_id, record_count, done, error}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        stim.delete(); add_hdr(); add_rec(8'h01, 8'h02, 8'h04, 8'h00, 32'h0012_3456);
        run_download(stim.size(), 1'b0);

        stim.delete(); add_hdr(); add_rec(8'h02, 8'h03, 8'h08, 8'h45, 32'h0ABC_DEF0);
        run_download(stim.size(), 1'b0);

        stim.delete(); add_hdr(); stim[2] = 8'h00; add_rec(8'h01, 8'h02, 8'h04, 8'h00, 32'h1);
        run_download(stim.size(), 1'b0);

        stim.delete(); add_hdr(); add_rec(8'h06, 8'h01, 8'h02, 8'h00, 32'h100);
        add_rec(8'h01, 8'h04, 8'h02, 8'h11, 32'h200);
        run_download(stim.size(), 1'b0);

        stim.delete(); add_hdr(); add_rec(8'h01, 8'h02, 8'h04, 8'h00, 32'h5);
        run_download(4 + 5, 1'b0);

        stim.delete(); add_hdr(); add_rec(8'h03, 8'h07, 8'h01, 8'h60, 32'hF000_0001);
        add_rec(8'h05, 8'h09, 8'h03, 8'h2A, 32'h0765_4321); add_rec(8'h0C, 8'h01, 8'h01, 8'h00, 32'h0);
        add_rec(8'h01, 8'h01, 8'h01, 8'h00, 32'h0);
        run_download(stim.size(), 1'b1);

        // Reset while the first page write is on the bus.
        stim.delete(); add_hdr(); add_rec(8'h01, 8'h03, 8'h04, 8'h00, 32'h77);
        start_dl();
        send_stream(stim.size(), 1'b0);
        @(negedge clk);
        ioctl_wr = 1'b0;
        check_eq("rst_pre_wr", slot_wr, 1);
        #2 reset = 1'b1;
        #1 check_eq("rst_mid_exp", {slot_wr, ioctl_wait, cfg_valid, record_count, done, error, cfg_typ}, 0);
        ioctl_download = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 25; d++) begin
            int n, nrec;
            stim.delete();
            add_hdr();
            if ($urandom_range(0, 9) == 0) begin
                int j;
                j = $urandom_range(0, 3);
                stim[j] = stim[j] ^ 8'h01;
            end
            nrec = $urandom_range(0, 5);
            for (int r = 0; r < nrec; r++) begin
                logic [7:0] b0;
                b0 = 8'($urandom);
                b0[4:0] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
                add_rec(b0, 8'($urandom), 8'($urandom_range(0, 6)), 8'($urandom), $urandom);
            end
            n = stim.size();
            if ($urandom_range(0, 5) == 0) n = $urandom_range(0, n);
            run_download(n, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/msx_config_loader.md
# msx_config_loader

Parses the machine-configuration byte stream delivered over the MiSTer ioctl download channel into configuration records and memory-block slot-table writes. Sits between the HPS ioctl interface and the slot/memory map logic: each record is emitted once as an `msx_config_t`-shaped field bundle, and slot-bearing records are expanded into one write per 16 KB page into the `mem_block[slot][sub_slot][page]` table.

## Interface
- `NONE`: no parameters; all widths fixed by the MSX package types.
- `clk  in  1  system clock`
- `reset  in  1  asynchronous, active-high reset`
- `ioctl_download  in  1  high while this config image is being transferred`
- `ioctl_wr  in  1  one-cycle strobe, `ioctl_dout` valid`
- `ioctl_dout  in  8  stream byte`
- `ioctl_wait  out  1  back-pressure to HPS; high while expanding a record`
- `cfg_valid  out  1  one-cycle pulse, record fields valid`
- `cfg_typ  out  5  config_typ_t`
- `cfg_block_id  out  4  block id`
- `cfg_block_count  out  8  block count`
- `cfg_slot`, `cfg_sub_slot`, `cfg_start_block  out  2 each  placement`
- `cfg_internal_mapper  out  1  slot_internal_mapper`
- `cfg_store_address  out  28  DDR3 store address`
- `slot_wr  out  1  slot-table write strobe`
- `slot_wr_slot`, `slot_wr_sub`, `slot_wr_page`, `slot_wr_offset  out  2 each  table index and mem_block offset`
- `slot_wr_typ  out  4  slot_typ_t`
- `slot_wr_block_id  out  4  block id`
- `record_count  out  8  records accepted this download (saturates at 255)`
- `done  out  1  sticky: stream completed cleanly`
- `error  out  1  sticky: stream malformed`

## Operation
- Stream: 4-byte header `0x4D 0x53 0x58 0x43` ("MSXC"), then N 8-byte records. Record bytes: b0[4:0]=typ; b1[3:0]=block_id; b2=block_count; b3[1:0]=slot, [3:2]=sub_slot, [4]=internal_mapper, [6:5]=start_block; b4..b7 = store_address little-endian, b7[7:4] ignored.
- FSM states: IDLE, HDR, REC, EXPAND, DONE, ERR.
- IDLE: rising `ioctl_download` -> HDR; clears `done`, `error`, `record_count`, byte index.
- HDR: compare each byte; mismatch -> ERR; fourth match -> REC.
- REC: accumulate bytes; on b7 accepted, latch all fields, check typ ≤ 9 (else ERR), increment `record_count`, -> EXPAND.
- EXPAND: pulse `cfg_valid` on entry cycle. Slot type map: RAM->RAM(1), or MAPPER(5) if internal_mapper; BIOS->ROM(2); FDC->FDC(8); CART_A->CART_A(6); CART_B->CART_B(7). Other typs (NONE, KBD_LAYOUT, mirrors): no writes. Writes k = min(block_count, 4-start_block) pages, page = start_block+i, offset = i, i = 0..k-1, one per cycle. k = 0 -> leave after one cycle. Then -> REC.
- Falling `ioctl_download`: in REC with byte index 0 -> DONE (`done`=1); in HDR, mid-record, or EXPAND -> ERR (`error`=1). In ERR/DONE, further bytes ignored until next rising download.
- `ioctl_wr` in IDLE/DONE/ERR ignored.

## Timing
- Reset: all outputs 0, state IDLE, holding register empty.
- b7 accepted on edge N: `cfg_valid`=1 and `ioctl_wait`=1 during cycle N+1; slot writes cycles N+1..N+k; `ioctl_wait` drops the cycle after the last write (N+2 when k≤1).
- `ioctl_wait` is registered; one byte arriving during the first EXPAND cycle is captured in a 1-byte holding register and consumed on the first REC cycle, no loss. A second byte while wait is high is a protocol violation -> ERR.
- `cfg_*` fields hold until the next record is latched; `slot_wr_*` are valid only with `slot_wr`.
- Rising `ioctl_download` in any state restarts parsing on the next cycle (abort in-flight expansion, no further writes).
- `reset` asserted mid-expansion: writes stop immediately, outputs to reset values.

## Test plan
- Header "MSXC" + record {typ=1,id=2,count=4,b3=0x00,addr=0x0123456} -> one `cfg_valid`, 4 writes slot0/sub0 pages 0..3 offsets 0..3 typ=1 id=2; download end -> `done`=1, `record_count`=1.
- Record typ=2, count=8, b3=0x45 (slot1, sub1, start=2) -> 2 writes pages 2,3 offsets 0,1 typ=2; count clipping verified.
- Header byte 2 = 0x00 -> `error`=1, no `cfg_valid`, no writes.
- Record typ=6 (KBD_LAYOUT) then typ=1 with b3[4]=1 -> first gives `cfg_valid` no writes; second writes typ=5.
- Download drops after 5 record bytes -> `error`=1, `done`=0; new download rise clears both.
- Back-to-back bytes with `ioctl_wr` on the cycle wait rises -> byte held, subsequent record parsed correctly; typ=12 record -> `error`.
